top_lvl: RTL and testbench

TOP_LVL -- requirements
Module: top_lvl

---
 rtl/calculator_pkg.sv | 16 +
 rtl/controller.sv | 84 ++++++++
 rtl/sram.sv | 36 +++
 rtl/top_lvl.sv | 52 +++++
 tb/tb_top_lvl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/calculator_pkg.sv
// Shared widths, memory geometry and controller state encoding for the
// pairwise 64-bit summing calculator.
package calculator_pkg;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_ADD,
        S_WRITE,
        S_END
    } state_t;
endpackage

// File: rtl/controller.sv
// Sequencer: reads operand pairs, adds them as 64-bit values and writes one
// result per four cycles until either address range is exhausted.
module controller
    import calculator_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   read_start_addr,
    input  logic [ADDR_W-1:0]   read_end_addr,
    input  logic [ADDR_W-1:0]   write_start_addr,
    input  logic [ADDR_W-1:0]   write_end_addr,
    input  logic [2*DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [ADDR_W-1:0]   w_addr,
    output logic                mem_we,
    output logic [2*DATA_W-1:0] mem_wdata
);
    state_t              state;
    logic [31:0]         cycle_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_end;
    logic [ADDR_W-1:0]   w_end;
    logic [2*DATA_W-1:0] op_a;
    logic [2*DATA_W-1:0] sum;

    assign mem_wdata = sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cycle_count <= '0;
            r_addr      <= read_start_addr;
            w_addr      <= write_start_addr;
            r_end       <= read_end_addr;
            w_end       <= write_end_addr;
            rd_addr     <= read_start_addr;
            op_a        <= '0;
            sum         <= '0;
            mem_we      <= 1'b0;
        end else begin
            if (state != S_IDLE && state != S_END)
                cycle_count <= cycle_count + 32'd1;
            case (state)
                S_IDLE: begin
                    r_addr  <= read_start_addr;
                    w_addr  <= write_start_addr;
                    r_end   <= read_end_addr;
                    w_end   <= write_end_addr;
                    rd_addr <= read_start_addr;
                    // Ranges too short for even one result never start.
                    if (({1'b0, read_end_addr} < {1'b0, read_start_addr} + 10'd1) ||
                        (write_end_addr < write_start_addr))
                        state <= S_END;
                    else
                        state <= S_READ_A;
                end
                S_READ_A: begin
                    rd_addr <= r_addr + ADDR_W'(1);
                    state   <= S_READ_B;
                end
                S_READ_B: begin
                    op_a  <= mem_rdata;
                    state <= S_ADD;
                end
                S_ADD: begin
                    sum    <= op_a + mem_rdata;
                    mem_we <= 1'b1;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    mem_we  <= 1'b0;
                    r_addr  <= r_addr + ADDR_W'(2);
                    w_addr  <= w_addr + ADDR_W'(1);
                    rd_addr <= r_addr + ADDR_W'(2);
                    if (({1'b0, r_addr} + 10'd1 >= {1'b0, r_end}) || (w_addr >= w_end))
                        state <= S_END;
                    else
                        state <= S_READ_A;
                end
                default: state <= S_END;
            endcase
        end
    end
endmodule

// File: rtl/sram.sv
// Single-port 512 x 32 SRAM with one-cycle registered read, plus the wrapper
// that hosts it as memory_mode_inst so the array can be loaded and dumped.
module sram_array
    import calculator_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] memory [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
        rdata <= memory[addr];
    end
endmodule

module sram
    import calculator_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    sram_array memory_mode_inst (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );
endmodule

// File: rtl/top_lvl.sv
// Calculator top: one controller driving two 32-bit SRAMs that together form
// 64-bit words (sram_B = high half, sram_A = low half) on a shared address.
module top_lvl
    import calculator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_start_addr,
    input  logic [ADDR_W-1:0] read_end_addr,
    input  logic [ADDR_W-1:0] write_start_addr,
    input  logic [ADDR_W-1:0] write_end_addr
);
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [2*DATA_W-1:0] mem_wdata;
    logic [2*DATA_W-1:0] mem_rdata;

    // The write address only owns the port during the single write cycle.
    assign mem_addr = mem_we ? w_addr : rd_addr;

    controller u_ctrl (
        .clk              (clk),
        .rst              (rst),
        .read_start_addr  (read_start_addr),
        .read_end_addr    (read_end_addr),
        .write_start_addr (write_start_addr),
        .write_end_addr   (write_end_addr),
        .mem_rdata        (mem_rdata),
        .rd_addr          (rd_addr),
        .w_addr           (w_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata)
    );

    sram sram_A (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata[DATA_W-1:0]),
        .rdata (mem_rdata[DATA_W-1:0])
    );

    sram sram_B (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata[2*DATA_W-1:DATA_W]),
        .rdata (mem_rdata[2*DATA_W-1:DATA_W])
    );
endmodule

// File: tb/tb_top_lvl.sv
// Randomized bench for top_lvl: preloads memory, predicts the final image
// from the pairwise-sum rules and compares every word plus controller status.
module tb_top_lvl;
    import calculator_pkg::*;

    logic              clk_tb = 1'b0;
    logic              rst    = 1'b1;
    logic [ADDR_W-1:0] read_start_addr  = '0;
    logic [ADDR_W-1:0] read_end_addr    = '0;
    logic [ADDR_W-1:0] write_start_addr = '0;
    logic [ADDR_W-1:0] write_end_addr   = '0;

    always #5 clk_tb = ~clk_tb;

    top_lvl dut (
        .clk              (clk_tb),
        .rst              (rst),
        .read_start_addr  (read_start_addr),
        .read_end_addr    (read_end_addr),
        .write_start_addr (write_start_addr),
        .write_end_addr   (write_end_addr)
    );

    int          checks   = 0;
    int          failures = 0;
    int          exp_cycles;
    logic [63:0] exp_q [$];
    logic [63:0] pre_mem [MEM_DEPTH];
    logic [63:0] model_mem [MEM_DEPTH];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input int a);
        return {dut.sram_B.memory_mode_inst.memory[a], dut.sram_A.memory_mode_inst.memory[a]};
    endfunction

    task automatic load_word(input int a, input logic [63:0] v);
        pre_mem[a] = v;
        dut.sram_A.memory_mode_inst.memory[a] = v[31:0];
        dut.sram_B.memory_mode_inst.memory[a] = v[63:32];
    endtask

    task automatic preload_random();
        for (int i = 0; i < MEM_DEPTH; i++)
            load_word(i, {$urandom(), $urandom()});
    endtask

    // Expected memory: results k = 0,1,.. until either range end is reached.
    task automatic build_model(input int rs, input int re, input int ws, input int we);
        int k;
        int n;
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = pre_mem[i];
        n = 0;
        if (re >= rs + 1 && we >= ws) begin
            k = 0;
            forever begin
                model_mem[ws + k] = pre_mem[rs + 2*k] + pre_mem[rs + 2*k + 1];
                n++;
                if (rs + 2*k + 1 >= re || ws + k >= we) break;
                k++;
            end
        end
        exp_cycles = 4 * n;
        exp_q.delete();
        for (int i = 0; i < MEM_DEPTH; i++) exp_q.push_back(model_mem[i]);
    endtask

    // Holds reset for two cycles with the new ranges applied and checks reset state.
    task automatic start_reset(input int rs, input int re, input int ws, input int we);
        @(negedge clk_tb);
        rst              = 1'b1;
        read_start_addr  = ADDR_W'(rs);
        read_end_addr    = ADDR_W'(re);
        write_start_addr = ADDR_W'(ws);
        write_end_addr   = ADDR_W'(we);
        @(posedge clk_tb);
        @(negedge clk_tb);
        check_val("rst_state", 64'(dut.u_ctrl.state), 64'(S_IDLE));
        check_val("rst_cycle_count", 64'(dut.u_ctrl.cycle_count), 64'd0);
        check_val("rst_w_addr", 64'(dut.w_addr), 64'(ws));
        @(posedge clk_tb);
        @(negedge clk_tb);
    endtask

    task automatic finish_run(input string tag);
        int budget;
        budget = 3000;
        while (dut.u_ctrl.state != S_END && budget > 0) begin
            @(negedge clk_tb);
            budget--;
        end
        check_val({tag, "_end_state"}, 64'(dut.u_ctrl.state), 64'(S_END));
        check_val({tag, "_cycles"}, 64'(dut.u_ctrl.cycle_count), 64'(exp_cycles));
        repeat (3) @(negedge clk_tb);
        check_val({tag, "_cycles_hold"}, 64'(dut.u_ctrl.cycle_count), 64'(exp_cycles));
        check_val({tag, "_state_hold"}, 64'(dut.u_ctrl.state), 64'(S_END));
        for (int i = 0; i < MEM_DEPTH; i++)
            check_val($sformatf("%s_mem[%0d]", tag, i), mem_word(i), exp_q.pop_front());
    endtask

    task automatic run_case(input string tag, input int rs, input int re, input int ws, input int we);
        start_reset(rs, re, ws, we);
        preload_random();
        build_model(rs, re, ws, we);
        rst = 1'b0;
        finish_run(tag);
    endtask

    initial begin
        int rs, re, ws, we, budget;

        // Full run over the whole operand area.
        run_case("full", 0, 255, 384, 511);

        // Carry from the low half into the high half.
        start_reset(0, 255, 384, 511);
        preload_random();
        load_word(0, 64'h00000000_FFFFFFFF);
        load_word(1, 64'h00000000_00000001);
        build_model(0, 255, 384, 511);
        rst = 1'b0;
        finish_run("carry");
        check_val("carry_word384", mem_word(384), 64'h00000001_00000000);

        // Carry out of bit 63 is dropped.
        start_reset(0, 255, 384, 511);
        preload_random();
        load_word(0, 64'hFFFFFFFF_FFFFFFFF);
        load_word(1, 64'h00000000_00000002);
        build_model(0, 255, 384, 511);
        rst = 1'b0;
        finish_run("ovf");
        check_val("ovf_word384", mem_word(384), 64'h00000000_00000001);

        // Short write window stops after four results.
        run_case("wlimit", 0, 255, 384, 387);
        check_val("wlimit_cycles_const", 64'(dut.u_ctrl.cycle_count), 64'd16);

        // Reset in the middle of a run, then rerun to completion.
        start_reset(0, 255, 384, 511);
        preload_random();
        build_model(0, 255, 384, 511);
        rst = 1'b0;
        budget = 1000;
        while (dut.u_ctrl.cycle_count != 32'd100 && budget > 0) begin
            @(negedge clk_tb);
            budget--;
        end
        check_val("mid_reached_100", 64'(dut.u_ctrl.cycle_count), 64'd100);
        rst = 1'b1;
        repeat (2) @(posedge clk_tb);
        @(negedge clk_tb);
        check_val("mid_rst_state", 64'(dut.u_ctrl.state), 64'(S_IDLE));
        check_val("mid_rst_cycles", 64'(dut.u_ctrl.cycle_count), 64'd0);
        rst = 1'b0;
        finish_run("mid_rerun");

        // Degenerate read range: nothing happens.
        run_case("empty", 5, 5, 384, 511);

        // Random ranges, including some that are too short to start.
        for (int t = 0; t < 4; t++) begin
            rs = $urandom_range(0, 200);
            re = $urandom_range(rs, rs + 50);
            ws = $urandom_range(300, 400);
            we = $urandom_range(ws - 3, ws + 60);
            run_case($sformatf("rand%0d", t), rs, re, ws, we);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
